// File: rtl/boot_sequencer_if.sv
// boot_sequencer_if: boot request/config, memory read (req/addr/ack/data), word stream (valid/data/ready) and status (busy/done/err)
interface boot_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W = 32
);
  logic start;
  logic abort;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic out_ready_i;
  logic busy_o;
  logic done_o;
  logic err_o;
  modport master (
    input start, abort, cfg_addr_i, cfg_len_i, mem_ack_i, mem_data_i, out_ready_i,
    output mem_req_o, mem_addr_o, out_valid_o, out_data_o, busy_o, done_o, err_o
  );
  modport slave (
    output start, abort, cfg_addr_i, cfg_len_i, mem_ack_i, mem_data_i, out_ready_i,
    input mem_req_o, mem_addr_o, out_valid_o, out_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/boot_sequencer.sv
// boot_sequencer: streams cfg_len_i boot words read from cfg_addr_i upward; ports clk, clr_n (sync active-low reset), bus (boot_sequencer_if.master)
module boot_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic clr_n,
  boot_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [7:0] timer;
  logic [DATA_W-1:0] data_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !bus.start ? IDLE : (bus.cfg_len_i != '0 ? FETCH : DONE);
      FETCH: state_nx = bus.mem_ack_i ? SEND : (timer == 8'(TIMEOUT) ? ERR : FETCH);
      SEND: state_nx = !bus.out_ready_i ? SEND : (remaining == LEN_W'(1) ? DONE : FETCH);
      DONE: state_nx = IDLE;
      ERR: state_nx = ERR;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end
  // timer sits at 0 outside FETCH, so every entry to FETCH starts a fresh count
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      timer <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      timer <= state == FETCH ? timer + 8'd1 : 8'd0;
      if (state == IDLE && state_nx == FETCH) begin
        cur_addr <= bus.cfg_addr_i;
        remaining <= bus.cfg_len_i;
      end
      if (state == FETCH && state_nx == SEND) data_q <= bus.mem_data_i;
      if (state == SEND && state_nx != SEND && state_nx != IDLE) begin
        remaining <= remaining - 1'b1;
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end
  assign bus.mem_req_o = state == FETCH;
  assign bus.mem_addr_o = state == FETCH ? cur_addr : '0;
  assign bus.out_valid_o = state == SEND;
  assign bus.out_data_o = data_q;
  assign bus.busy_o = state == FETCH || state == SEND;
  assign bus.done_o = state == DONE;
  assign bus.err_o = state == ERR;
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: randomized boots checked against a transaction-level model of expected addresses, words and handshake latencies
module tb_boot_sequencer;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [256];
  boot_sequencer_if #(.ADDR_W(8), .DATA_W(32), .LEN_W(32)) bus ();
  boot_sequencer #(.ADDR_W(8), .DATA_W(32), .LEN_W(32), .TIMEOUT(TO)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask
  task automatic check_off(input string tag);
    check({tag, "_req"}, bus.mem_req_o, 0);
    check({tag, "_valid"}, bus.out_valid_o, 0);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
  endtask
  task automatic check_reset(input string tag);
    check_off(tag);
    check({tag, "_addr"}, bus.mem_addr_o, 0);
    check({tag, "_data"}, bus.out_data_o, 0);
  endtask
  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask
  // One boot: memory acks with probability ack_pct, downstream accepts with ready_pct
  // after holding off `hold` valid cycles per word; rst_at >= 0 resets while word rst_at is offered.
  task automatic run_boot(input logic [7:0] a, input int len, input int ack_pct, input int ready_pct, input int hold, input int rst_at);
    int rd = 0;
    int wr = 0;
    int budget = 0;
    int vcnt = 0;
    bit acked = 0;
    bit readied = 0;
    bit got_done = 0;
    fill_mem();
    bus.cfg_addr_i = a;
    bus.cfg_len_i = len;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cfg_addr_i = 8'($urandom);
    bus.cfg_len_i = $urandom_range(1, 50);
    check("req_after_start", bus.mem_req_o, len != 0);
    if (len == 0) check("zero_len_done", bus.done_o, 1);
    while (!got_done && budget < 5000) begin
      if (acked) check("valid_after_ack", bus.out_valid_o, 1);
      if (readied && wr < len) check("req_after_ready", bus.mem_req_o, 1);
      if (readied && wr == len) check("done_after_last", bus.done_o, 1);
      check("no_overlap", bus.mem_req_o & bus.out_valid_o, 0);
      check("busy", bus.busy_o, bus.mem_req_o | bus.out_valid_o);
      check("err_low", bus.err_o, 0);
      acked = 0;
      readied = 0;
      bus.mem_ack_i = 1'b0;
      bus.out_ready_i = 1'b0;
      bus.mem_data_i = $urandom;
      bus.start = $urandom_range(3) == 0;
      if (bus.mem_req_o) begin
        check("addr", bus.mem_addr_o, 8'(a + rd));
        check("read_in_range", rd < len, 1);
        if ($urandom_range(99) < ack_pct) begin
          bus.mem_ack_i = 1'b1;
          bus.mem_data_i = mem[bus.mem_addr_o];
          acked = 1;
          rd++;
        end
      end
      if (bus.out_valid_o) begin
        check("data", bus.out_data_o, mem[8'(a + wr)]);
        if (rst_at >= 0 && wr == rst_at) begin
          idle_inputs();
          clr_n = 1'b0;
          tick();
          check_reset("mid_reset");
          clr_n = 1'b1;
          tick();
          return;
        end
        if (vcnt >= hold && $urandom_range(99) < ready_pct) begin
          bus.out_ready_i = 1'b1;
          readied = 1;
          wr++;
          vcnt = 0;
        end else vcnt++;
      end
      if (bus.done_o) begin
        got_done = 1;
        check("done_count", wr, len);
      end
      tick();
      budget++;
    end
    idle_inputs();
    check("done_seen", got_done, 1);
    check("done_one_cycle", bus.done_o, 0);
    check("busy_after", bus.busy_o, 0);
  endtask
  // Memory never acks; optionally ack exactly on the last allowed FETCH cycle.
  task automatic run_timeout(input bit ack_last);
    int n = 0;
    bus.cfg_addr_i = 8'($urandom);
    bus.cfg_len_i = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.mem_req_o && n < 400) begin
      n++;
      check("to_err_low", bus.err_o, 0);
      if (ack_last && n == TO + 1) begin
        bus.mem_ack_i = 1'b1;
        bus.mem_data_i = 32'hC0DE_0000 + 32'(n);
      end
      tick();
      bus.mem_ack_i = 1'b0;
    end
    check("to_fetch_cycles", n, TO + 1);
    if (ack_last) begin
      check("to_ack_valid", bus.out_valid_o, 1);
      check("to_ack_err", bus.err_o, 0);
      check("to_ack_data", bus.out_data_o, 32'hC0DE_0000 + 32'(TO + 1));
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      check("to_ack_done", bus.done_o, 1);
      tick();
    end else begin
      check("to_err", bus.err_o, 1);
      check("to_err_req", bus.mem_req_o, 0);
      check("to_err_valid", bus.out_valid_o, 0);
      check("to_err_busy", bus.busy_o, 0);
      bus.start = 1'b1;
      repeat (3) tick();
      bus.start = 1'b0;
      check("to_err_sticky", bus.err_o, 1);
      check("to_err_start_ignored", bus.mem_req_o, 0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_off("to_abort");
      tick();
      check("to_abort_no_done", bus.done_o, 0);
    end
  endtask
  task automatic run_abort();
    int k = $urandom_range(2, 12);
    bus.cfg_addr_i = 8'($urandom);
    bus.cfg_len_i = 10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (k) begin
      bus.mem_ack_i = bus.mem_req_o && $urandom_range(1) == 1;
      bus.mem_data_i = $urandom;
      bus.out_ready_i = $urandom_range(1) == 1;
      tick();
    end
    check("abort_pre_busy", bus.busy_o, 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.mem_ack_i = 1'b1;
    bus.out_ready_i = 1'b1;
    tick();
    idle_inputs();
    check_off("abort");
    tick();
    check_off("abort_after");
  endtask
  initial begin
    idle_inputs();
    bus.cfg_addr_i = '0;
    bus.cfg_len_i = '0;
    bus.mem_data_i = '0;
    repeat (3) tick();
    check_reset("reset");
    clr_n = 1'b1;
    tick();
    check_reset("post_reset");
    bus.cfg_len_i = 5;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    check_off("abort_vs_start");
    run_boot(8'd3, 4, 100, 100, 0, -1);
    run_boot(8'd3, 6, 100, 60, 5, -1);
    run_boot(8'hFE, 3, 60, 70, 0, -1);
    run_boot(8'h20, 0, 100, 100, 0, -1);
    run_timeout(1'b0);
    run_timeout(1'b1);
    run_abort();
    repeat (6) run_boot(8'($urandom), $urandom_range(1, 20), $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 2), -1);
    run_boot(8'($urandom), 400, 80, 80, 0, 1);
    run_boot(8'd3, 4, 100, 100, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 8, boot memory address width.
REQ-002 DATA_W, 32, boot word width.
REQ-003 LEN_W, 32, word-count width.
REQ-004 TIMEOUT, 255, maximum cycles in FETCH before an error is raised.
REQ-005 Ports SHALL be (name, direction, width, meaning): clk, input, 1, sole clock, rising edge.
REQ-006 clr_n, input, 1, reset, synchronous and active-low.
REQ-007 start, input, 1, single-cycle boot request.
REQ-008 abort, input, 1, cancel the current boot.
REQ-009 cfg_addr_i, input, ADDR_W, boot start address from the bootloader register.
REQ-010 cfg_len_i, input, LEN_W, boot word count from the bootloader register.
REQ-011 mem_req_o, output, 1, memory read request.
REQ-012 mem_addr_o, output, ADDR_W, memory read address.
REQ-013 mem_ack_i, input, 1, memory read acknowledge; mem_data_i is valid in the same cycle.
REQ-014 mem_data_i, input, DATA_W, memory read data.
REQ-015 out_valid_o, output, 1, boot word available downstream.
REQ-016 out_data_o, output, DATA_W, boot word.
REQ-017 out_ready_i, input, 1, downstream accepts the word.
REQ-018 busy_o, output, 1, high while in FETCH or SEND.
REQ-019 done_o, output, 1, one-cycle pulse on successful completion.
REQ-020 err_o, output, 1, sticky timeout error.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, FETCH, SEND, DONE and ERR, held in registers.
REQ-022 IDLE, start=1, cfg_len_i!=0: latch cfg_addr_i into cur_addr and cfg_len_i into remaining, then go to FETCH.
REQ-023 IDLE, start=1, cfg_len_i==0: go to DONE without issuing any memory request.
REQ-024 FETCH: mem_req_o=1 and mem_addr_o=cur_addr; an 8-bit wait timer increments every cycle and clears on entry to FETCH.
REQ-025 FETCH, mem_ack_i=1: register mem_data_i into out_data_o, then go to SEND; mem_req_o falls in the next cycle.
REQ-026 FETCH, timer==TIMEOUT with mem_ack_i=0: go to ERR; an ack arriving in that same cycle SHALL take priority and the block SHALL go to SEND.
REQ-027 SEND: out_valid_o=1 and out_data_o SHALL be held stable until out_ready_i=1.
REQ-028 SEND, out_ready_i=1: decrement remaining, set cur_addr=cur_addr+1 modulo 2^ADDR_W (0xFF wraps to 0x00 with no error), then go to DONE if remaining was 1, otherwise to FETCH.
REQ-029 DONE: done_o=1 for exactly one cycle, then go to IDLE.
REQ-030 ERR: err_o=1 with mem_req_o=0 and out_valid_o=0; the block SHALL remain in ERR until abort or reset.
REQ-031 abort=1 in any state SHALL go to IDLE on the next edge, drop mem_req_o and out_valid_o, clear err_o, and produce no done_o pulse.
REQ-032 abort SHALL have priority over start, ack, ready and timeout occurring in the same cycle.
REQ-033 start SHALL be ignored outside IDLE.
REQ-034 cfg_addr_i and cfg_len_i SHALL be sampled only at a start accepted in IDLE; later changes SHALL not affect a boot in progress.
REQ-035 Latency: start accepted at edge N gives mem_req_o=1 in cycle N+1.
REQ-036 Latency: ack at edge M gives out_valid_o=1 in cycle M+1.
REQ-037 Latency: ready at edge K gives the next mem_req_o=1 in cycle K+1.
REQ-038 Throughput SHALL be at most one word per two cycles.
REQ-039 remaining SHALL be LEN_W bits wide and SHALL never underflow.

Reset
REQ-040 clr_n=0 at a rising clk edge SHALL force state=IDLE and clear cur_addr, remaining, timer and out_data_o to 0.
REQ-041 During and after that reset, all outputs (mem_req_o, mem_addr_o, out_valid_o, out_data_o, busy_o, done_o, err_o) SHALL be 0.
REQ-042 Reset SHALL override every other input, including when asserted mid-transfer.
REQ-043 No output SHALL change asynchronously to clk.

Verification
REQ-044 Basic boot: cfg_addr_i=3, cfg_len_i=4, start pulse, memory acks one cycle after each req, out_ready_i=1 -> reads at addresses 3,4,5,6, four words out in order, done_o pulses once, busy_o low afterwards.
REQ-045 Backpressure: out_ready_i=0 for 5 cycles during SEND -> out_valid_o and out_data_o stable, no new mem_req_o, no word lost or duplicated.
REQ-046 Wrap: cfg_addr_i=0xFE, cfg_len_i=3 -> addresses 0xFE, 0xFF, 0x00, done_o pulses, err_o=0.
REQ-047 Timeout: mem_ack_i held at 0 -> err_o=1 after 255 cycles in FETCH; abort -> IDLE with err_o=0; ack on the timeout cycle -> SEND.
REQ-048 Zero length and ignored start: cfg_len_i=0 with start -> done_o one cycle later and no mem_req_o; start while busy -> no effect.
REQ-049 Reset mid-transfer: clr_n=0 during SEND of word 2 of 400 -> all outputs 0 next cycle; a fresh start after release behaves as in REQ-044.
